fir_interp_coef_ctrl: RTL and testbench
=======================================

Name: fir_interp_coef_ctrl

Overview:
Sequencer in front of the FIR interpolator computation unit. It owns the unit's coefficient write port and its input sample stream. It reloads all coefficients from a host valid/ready stream, then flushes the filter delay line with zero samples. In normal operation it enforces the minimum input-sample spacing of INTERPOLATION clocks that the interpolator requires.

Parameters:
FILTER_ORDER, 256, number of taps; must be a multiple of INTERPOLATION (elaboration error otherwise)
INTERPOLATION, 32, upsampling factor; minimum clocks between samples delivered to the filter
DATA_WIDTH, 16, sample width
COEF_WIDTH, 16, coefficient width
COEF_AWIDTH, $clog2(FILTER_ORDER), coefficient address width; not overridable (elaboration error if changed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
load_start_i  in  1  single-cycle request to start a coefficient reload
coef_i  in  COEF_WIDTH  host coefficient, tap order 0..FILTER_ORDER-1
coef_val_i  in  1  host coefficient valid
coef_rdy_o  out  1  ready for host coefficient
data_i  in  DATA_WIDTH signed  upstream sample
data_val_i  in  1  upstream sample valid (no backpressure)
fir_data_o  out  DATA_WIDTH signed  sample to filter
fir_data_val_o  out  1  sample valid to filter
fir_coef_we_o  out  1  coefficient write enable to filter
fir_coef_addr_o  out  COEF_AWIDTH  coefficient address
fir_coef_data_o  out  COEF_WIDTH  coefficient data
busy_o  out  1  high in LOAD or FLUSH
done_o  out  1  one-cycle pulse when reload + flush complete
err_o  out  2  one-cycle pulses: [0] sample dropped for spacing violation, [1] sample dropped during reload

Behaviour:
- Reset: state IDLE, spacing counter 0, address counter 0, flush counter 0. All outputs 0.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - Accepted sample is registered to fir_data_o/fir_data_val_o with 1-clock latency.
  - A sample is accepted only if the spacing counter is 0. Acceptance loads the counter with INTERPOLATION-1; it then decrements to 0 and holds there.
  - data_val_i while counter != 0: sample dropped, err_o[0] pulses next cycle.
  - load_start_i -> LOAD, address counter cleared. A sample arriving in the same cycle as load_start_i is dropped with err_o[1].
- LOAD:
  - coef_rdy_o=1. Each coef_val_i&coef_rdy_o handshake drives we=1 with addr=counter and data=coef_i on the next clock, then increments the counter.
  - The handshake at address FILTER_ORDER-1 -> FLUSH; coef_rdy_o drops in the same cycle the state changes.
  - load_start_i in LOAD restarts: address counter reset to 0, no write for that cycle's handshake.
- FLUSH:
  - coef_rdy_o=0.
  - Emits FILTER_ORDER/INTERPOLATION zero samples on fir_data_o with fir_data_val_o. The first is emitted on the cycle after entry; subsequent ones are exactly INTERPOLATION clocks apart.
  - After the last zero is emitted, the spacing counter is loaded with INTERPOLATION-1, the state goes to IDLE, and done_o pulses together with the last zero's valid.
  - load_start_i in FLUSH -> LOAD (abort flush, address 0, no done_o).
- LOAD/FLUSH input: every data_val_i is dropped and err_o[1] pulses next cycle.
- fir_data_o is held (not zeroed) while fir_data_val_o=0. fir_coef_addr_o and fir_coef_data_o are held between writes.
- rst_i in any state returns to the reset condition on the next clock. A partial load is left in the filter as is; no done_o is issued.
- Counter widths:
  - address: COEF_AWIDTH.
  - spacing: $clog2(INTERPOLATION).
  - flush: $clog2(FILTER_ORDER/INTERPOLATION)+1.
  - No wrap: address terminal count is FILTER_ORDER-1.

Decomposition:
- Package fir_interp_pkg: state enum type (IDLE/LOAD/FLUSH), err bit index constants (ERR_SPACING=0, ERR_RELOAD=1).
- Sub-module fir_interp_rate_guard: spacing counter plus accept/drop decision. It has inputs for valid and force-load, and outputs accept and drop. It is reused for FLUSH zero pacing.
- The FSM and address counter stay in the top module.

Test Plan:
- Pass-through: samples 100, -200 at cycle 0 and cycle 32 (defaults) -> fir_data_val_o at cycles 1 and 33 with the same values; err_o=0.
- Spacing violation: samples at cycles 0 and 10 -> first forwarded at cycle 1; second dropped with err_o[0] at cycle 11. Sample at cycle 32 is accepted.
- Full reload:
  - Stimulus: load_start_i, then 256 back-to-back coefficients k (value=k).
  - Writes: 256 writes, addr=k, data=k, contiguous.
  - Flush: 8 zero samples spaced 32 clocks apart.
  - Completion: done_o coincides with the 8th zero; busy_o high throughout.
- Host throttling: coef_val_i toggled every other cycle -> writes only on handshakes, addresses contiguous, no skipped or duplicated address.
- Restart/abort:
  - load_start_i at coefficient 100 -> next write is addr 0.
  - load_start_i during the 3rd flush zero -> back to LOAD, no done_o.
  - Samples during reload -> err_o[1] each, none forwarded.
- Reset mid-LOAD at coefficient 50 -> next cycle all outputs 0, state IDLE. A sample 2 cycles later is forwarded normally.

Source files
------------

// File: rtl/fir_interp_pkg.sv
// Shared types and constants for the FIR interpolator coefficient/sample sequencer.
package fir_interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int ERR_SPACING = 0;
  localparam int ERR_RELOAD  = 1;

endpackage

// File: rtl/fir_interp_rate_guard.sv
// Minimum-spacing guard: accepts a request only when the spacing counter has run down,
// then reloads it so the next acceptance is at least INTERPOLATION clocks later.
module fir_interp_rate_guard #(
  parameter int INTERPOLATION = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic force_load_i,
  output logic accept_o,
  output logic drop_o
);

  localparam int CW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INTERPOLATION - 1);

  logic [CW-1:0] cnt_q;

  assign accept_o = valid_i && (cnt_q == '0);
  assign drop_o   = valid_i && (cnt_q != '0);

  // Counter runs down to zero and parks there until the next acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept_o || force_load_i) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/fir_interp_coef_ctrl.sv
// Sequencer in front of the FIR interpolator: coefficient reload from a host stream,
// delay-line flush with zero samples, and input sample spacing enforcement.
module fir_interp_coef_ctrl
  import fir_interp_pkg::*;
#(
  parameter int FILTER_ORDER  = 256,
  parameter int INTERPOLATION = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int COEF_WIDTH    = 16,
  parameter int COEF_AWIDTH   = $clog2(FILTER_ORDER)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_start_i,
  input  logic [COEF_WIDTH-1:0]        coef_i,
  input  logic                         coef_val_i,
  output logic                         coef_rdy_o,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         data_val_i,
  output logic signed [DATA_WIDTH-1:0] fir_data_o,
  output logic                         fir_data_val_o,
  output logic                         fir_coef_we_o,
  output logic [COEF_AWIDTH-1:0]       fir_coef_addr_o,
  output logic [COEF_WIDTH-1:0]        fir_coef_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   err_o,
  output state_t                       state_o
);

  localparam int N_ZEROS = FILTER_ORDER / INTERPOLATION;
  localparam int FW      = $clog2(N_ZEROS) + 1;
  localparam logic [FW-1:0]          LAST_ZERO = FW'(N_ZEROS - 1);
  localparam logic [COEF_AWIDTH-1:0] LAST_ADDR = COEF_AWIDTH'(FILTER_ORDER - 1);

  if ((FILTER_ORDER % INTERPOLATION) != 0) begin : g_bad_ratio
    $error("FILTER_ORDER must be a multiple of INTERPOLATION");
  end
  if (COEF_AWIDTH != $clog2(FILTER_ORDER)) begin : g_bad_awidth
    $error("COEF_AWIDTH must equal clog2(FILTER_ORDER)");
  end

  // Handshake: a coefficient transfers on any cycle where coef_val_i && coef_rdy_o;
  // the host holds coef_i stable while coef_val_i is high and coef_rdy_o is low.

  state_t                 state_q, state_d;
  logic [COEF_AWIDTH-1:0] addr_q;
  logic [FW-1:0]          flush_q;

  logic       guard_valid, guard_accept, guard_drop;
  logic       coef_wr, load_clear, sample_fwd, zero_fwd, zero_last, done_d;
  logic [1:0] err_d;

  assign guard_valid = !load_start_i &&
                       (((state_q == ST_IDLE) && data_val_i) || (state_q == ST_FLUSH));

  fir_interp_rate_guard #(
    .INTERPOLATION(INTERPOLATION)
  ) u_rate_guard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (guard_valid),
    .force_load_i(zero_last),
    .accept_o    (guard_accept),
    .drop_o      (guard_drop)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    coef_wr    = 1'b0;
    load_clear = 1'b0;
    sample_fwd = 1'b0;
    zero_fwd   = 1'b0;
    zero_last  = 1'b0;
    done_d     = 1'b0;
    err_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d            = ST_LOAD;
          load_clear         = 1'b1;
          err_d[ERR_RELOAD]  = data_val_i;
        end else begin
          sample_fwd         = guard_accept;
          err_d[ERR_SPACING] = guard_drop;
        end
      end
      ST_LOAD: begin
        err_d[ERR_RELOAD] = data_val_i;
        if (load_start_i) begin
          load_clear = 1'b1;
        end else if (coef_val_i) begin
          coef_wr = 1'b1;
          if (addr_q == LAST_ADDR) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        err_d[ERR_RELOAD] = data_val_i;
        if (load_start_i) begin
          state_d    = ST_LOAD;
          load_clear = 1'b1;
        end else begin
          zero_fwd = guard_accept;
          if (guard_accept && (flush_q == LAST_ZERO)) begin
            zero_last = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address stops at the last tap rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_clear) begin
      addr_q <= '0;
    end else if (coef_wr && (addr_q != LAST_ADDR)) begin
      addr_q <= addr_q + COEF_AWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != ST_FLUSH)) begin
      flush_q <= '0;
    end else if (zero_fwd) begin
      flush_q <= flush_q + FW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fir_coef_we_o   <= 1'b0;
      fir_coef_addr_o <= '0;
      fir_coef_data_o <= '0;
      fir_data_o      <= '0;
      fir_data_val_o  <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= '0;
    end else begin
      fir_coef_we_o  <= coef_wr;
      fir_data_val_o <= sample_fwd || zero_fwd;
      done_o         <= done_d;
      err_o          <= err_d;
      if (coef_wr) begin
        fir_coef_addr_o <= addr_q;
        fir_coef_data_o <= coef_i;
      end
      if (sample_fwd)    fir_data_o <= data_i;
      else if (zero_fwd) fir_data_o <= '0;
    end
  end

  assign coef_rdy_o = (state_q == ST_LOAD);
  assign busy_o     = (state_q != ST_IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_fir_interp_coef_ctrl.sv
// Directed bench for fir_interp_coef_ctrl at default parameters (256 taps, x32).
module tb_fir_interp_coef_ctrl;
  import fir_interp_pkg::*;

  localparam int FO = 256;
  localparam int IP = 32;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 load_start = 1'b0;
  logic [CW-1:0]        coef = '0;
  logic                 coef_val = 1'b0;
  logic                 coef_rdy;
  logic signed [DW-1:0] data = '0;
  logic                 data_val = 1'b0;
  logic signed [DW-1:0] fir_data;
  logic                 fir_data_val;
  logic                 fir_coef_we;
  logic [AW-1:0]        fir_coef_addr;
  logic [CW-1:0]        fir_coef_data;
  logic                 busy;
  logic                 done;
  logic [1:0]           err;
  state_t               state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [AW+CW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  fir_interp_coef_ctrl #(
    .FILTER_ORDER (FO),
    .INTERPOLATION(IP),
    .DATA_WIDTH   (DW),
    .COEF_WIDTH   (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_start_i   (load_start),
    .coef_i         (coef),
    .coef_val_i     (coef_val),
    .coef_rdy_o     (coef_rdy),
    .data_i         (data),
    .data_val_i     (data_val),
    .fir_data_o     (fir_data),
    .fir_data_val_o (fir_data_val),
    .fir_coef_we_o  (fir_coef_we),
    .fir_coef_addr_o(fir_coef_addr),
    .fir_coef_data_o(fir_coef_data),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .state_o        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_sample(input logic signed [DW-1:0] v);
    data     = v;
    data_val = 1'b1;
    tick();
    data_val = 1'b0;
  endtask

  task automatic check_write(input string tag);
    logic [AW+CW-1:0] e;
    chk({tag, "_we"}, 32'(fir_coef_we), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, 32'(fir_coef_addr), 32'(e[AW+CW-1:CW]));
      chk({tag, "_data"}, 32'(fir_coef_data), 32'(e[CW-1:0]));
    end
  endtask

  task automatic send_coef(input int addr, input logic [CW-1:0] v, input string tag);
    coef     = v;
    coef_val = 1'b1;
    exp_q.push_back({8'(addr), v});
    tick();
    coef_val = 1'b0;
    check_write(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    32'(fir_coef_we),   32'd0);
    chk({tag, "_addr"},  32'(fir_coef_addr), 32'd0);
    chk({tag, "_cdata"}, 32'(fir_coef_data), 32'd0);
    chk({tag, "_data"},  32'(fir_data),      32'd0);
    chk({tag, "_dval"},  32'(fir_data_val),  32'd0);
    chk({tag, "_rdy"},   32'(coef_rdy),      32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
    chk({tag, "_err"},   32'(err),           32'd0);
    chk({tag, "_state"}, 32'(state),         32'(ST_IDLE));
  endtask

  // wait out one zero spacing gap while confirming nothing is emitted
  task automatic flush_gap(input string tag);
    for (int i = 0; i < IP - 1; i++) begin
      tick();
      chk({tag, "_gap_val"},  32'(fir_data_val), 32'd0);
      chk({tag, "_gap_busy"}, 32'(busy),         32'd1);
    end
    tick();
  endtask

  initial begin
    // reset
    ticks(2);
    check_all_zero("rst");
    rst = 1'b0;
    tick();

    // pass-through: samples at cycle 0 and cycle 32
    send_sample(16'sd100);
    chk("pt0_val",  32'(fir_data_val), 32'd1);
    chk("pt0_data", 32'(fir_data),     32'(100));
    chk("pt0_err",  32'(err),          32'd0);
    tick();
    chk("pt_hold_val",  32'(fir_data_val), 32'd0);
    chk("pt_hold_data", 32'(fir_data),     32'(100));
    ticks(30);
    send_sample(-16'sd200);
    chk("pt1_val",  32'(fir_data_val), 32'd1);
    chk("pt1_data", 32'(fir_data),     32'(-200));
    chk("pt1_err",  32'(err),          32'd0);

    // spacing: accept at 0, drop at 10 and 31, accept at 32
    ticks(40);
    send_sample(16'sd7);
    chk("sp0_val", 32'(fir_data_val), 32'd1);
    ticks(9);
    send_sample(16'sd8);
    chk("sp10_val",  32'(fir_data_val), 32'd0);
    chk("sp10_err",  32'(err),          32'd1);
    chk("sp10_hold", 32'(fir_data),     32'(7));
    ticks(20);
    send_sample(16'sd55);
    chk("sp31_val", 32'(fir_data_val), 32'd0);
    chk("sp31_err", 32'(err),          32'd1);
    send_sample(16'sd9);
    chk("sp32_val",  32'(fir_data_val), 32'd1);
    chk("sp32_data", 32'(fir_data),     32'(9));
    chk("sp32_err",  32'(err),          32'd0);

    // full back-to-back reload, one sample arrives during it
    ticks(40);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld_busy",  32'(busy),        32'd1);
    chk("ld_rdy",   32'(coef_rdy),    32'd1);
    chk("ld_state", 32'(state),       32'(ST_LOAD));
    chk("ld_we",    32'(fir_coef_we), 32'd0);
    for (int k = 0; k < FO; k++) begin
      data     = 16'sd77;
      data_val = (k == 5);
      send_coef(k, 16'(k), "ld");
      data_val = 1'b0;
      chk("ld_busy_k", 32'(busy),     32'd1);
      chk("ld_rdy_k",  32'(coef_rdy), 32'(k != FO - 1));
      if (k == 5) begin
        chk("ld_smp_err", 32'(err),          32'd2);
        chk("ld_smp_val", 32'(fir_data_val), 32'd0);
      end
    end
    chk("ld_to_flush", 32'(state), 32'(ST_FLUSH));
    for (int z = 0; z < FO / IP; z++) begin
      if (z == 0) tick();
      else        flush_gap("fl");
      chk("fl_val",  32'(fir_data_val), 32'd1);
      chk("fl_data", 32'(fir_data),     32'd0);
      chk("fl_done", 32'(done),         32'(z == FO / IP - 1));
      chk("fl_busy", 32'(busy),         32'(z != FO / IP - 1));
    end
    chk("fl_state", 32'(state), 32'(ST_IDLE));
    send_sample(16'sd11);
    chk("post_fl_val", 32'(fir_data_val), 32'd0);
    chk("post_fl_err", 32'(err),          32'd1);
    chk("post_fl_done", 32'(done),        32'd0);
    ticks(30);
    send_sample(16'sd12);
    chk("post_fl32_val",  32'(fir_data_val), 32'd1);
    chk("post_fl32_data", 32'(fir_data),     32'(12));

    // throttled host, restart at coefficient 100
    ticks(40);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      send_coef(k, 16'(k), "thr");
      tick();
      chk("thr_idle_we",   32'(fir_coef_we),   32'd0);
      chk("thr_idle_addr", 32'(fir_coef_addr), 32'(k));
    end
    coef       = 16'd100;
    coef_val   = 1'b1;
    load_start = 1'b1;
    tick();
    coef_val   = 1'b0;
    load_start = 1'b0;
    chk("rs_we",    32'(fir_coef_we),   32'd0);
    chk("rs_addr",  32'(fir_coef_addr), 32'd99);
    chk("rs_state", 32'(state),         32'(ST_LOAD));
    send_coef(0, 16'h0007, "rs_first");
    for (int k = 1; k < FO; k++) send_coef(k, 16'(16'hA000 + k), "rs");

    // abort flush on the third zero
    tick();
    chk("ab_z1", 32'(fir_data_val), 32'd1);
    flush_gap("ab");
    chk("ab_z2", 32'(fir_data_val), 32'd1);
    flush_gap("ab");
    chk("ab_z3", 32'(fir_data_val), 32'd1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ab_state", 32'(state),        32'(ST_LOAD));
    chk("ab_done",  32'(done),         32'd0);
    chk("ab_val",   32'(fir_data_val), 32'd0);
    chk("ab_busy",  32'(busy),         32'd1);

    // reset in the middle of a load
    for (int k = 0; k < 50; k++) send_coef(k, 16'(16'h5000 + k), "mr");
    coef     = 16'd50;
    coef_val = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    coef_val = 1'b0;
    check_all_zero("mr_rst");
    tick();
    send_sample(16'sd321);
    chk("mr_smp_val",  32'(fir_data_val), 32'd1);
    chk("mr_smp_data", 32'(fir_data),     32'(321));
    chk("mr_smp_err",  32'(err),          32'd0);
    chk("sb_drained",  32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
